wr_resp_sched: RTL and testbench
================================

Name: wr_resp_sched

Overview:
- Collects write responses from NUM_SRC write-completion sources (cache banks or write ports).
- Queues each response per destination direction and returns it on that direction's valid/ready wresp channel.
- Sits between the per-bank write-response decode and the NUM_DIR upstream master ports.
- Shares each direction's return channel fairly among the sources using one round-robin arbiter per direction.

Parameters:
- NUM_SRC, 4, number of response sources.
- NUM_DIR, 4, number of directions. Must equal 2^width of txnid.direction_id.
- FIFO_DEPTH, 4, entries per direction FIFO. Power of 2, at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- v_src_vld  input  NUM_SRC  per-source response valid.
- v_src_rdy  output  NUM_SRC  per-source accept.
- v_src_pld  input  wr_resp_pld_t[NUM_SRC]  response payload. txnid.direction_id selects the direction.
- v_dir_vld  output  NUM_DIR  per-direction response valid.
- v_dir_rdy  input  NUM_DIR  per-direction downstream ready.
- v_dir_pld  output  wr_resp_pld_t[NUM_DIR]  per-direction response, carried unmodified.
- idle  output  1  high when all FIFOs are empty and no v_src_vld is asserted.

Behaviour:
- Single clock domain. All state is updated on the rising edge of clk.
- Reset: while rst=1, all FIFO counts, read pointers and write pointers go to 0, and every rr_ptr[d] goes to 0. v_dir_vld=0 and v_src_rdy=0 during reset and in the first cycle after it. idle=1 unless a v_src_vld is high.
- Reset asserted mid-operation discards all queued responses and does not complete any in-flight handshake.
- Request decode, per direction d: req_d[s] = v_src_vld[s] && v_src_pld[s].txnid.direction_id==d.
- Arbitration, per direction d:
  - The grant goes to the first s with req_d[s]=1, searching from rr_ptr[d] upward with wrap modulo NUM_SRC.
  - The grant is issued only when cnt[d] < FIFO_DEPTH.
  - v_src_rdy[s]=1 iff source s holds the direction grant. At most one accept per direction per cycle.
  - Each source targets exactly one direction, so at most one grant per source.
- v_src_rdy is combinational from v_src_vld, v_src_pld and registered state. It does not depend on v_dir_rdy.
- Pointer update: on an accepted grant to source g, rr_ptr[d] <= (g+1) mod NUM_SRC. With no accept, rr_ptr[d] holds.
- Fairness: a continuously requesting source waits at most NUM_SRC-1 accepts on its direction.
- FIFO, per direction:
  - Push on accept. Pop when v_dir_vld[d] && v_dir_rdy[d].
  - v_dir_vld[d] = (cnt[d]!=0). v_dir_pld[d] = head entry, driven from registers.
  - Latency: accept in cycle N gives v_dir_vld in cycle N+1 at the earliest. There is no combinational bypass.
  - Full: cnt==FIFO_DEPTH blocks push even if a pop occurs in the same cycle. The freed slot is usable the next cycle.
  - Simultaneous push and pop with 0<cnt<FIFO_DEPTH leaves cnt unchanged.
  - Pointers wrap modulo FIFO_DEPTH. cnt is $clog2(FIFO_DEPTH)+1 bits wide.
- Ordering:
  - Per direction, output order equals accept order.
  - Per source per direction, responses stay in order.
  - There is no ordering guarantee across directions.
- Output stability: v_dir_vld and v_dir_pld hold until popped, because the head does not change without a pop.
- Source protocol: the source holds vld and pld stable until rdy. Violations are not detected. The SVA flags v_src_vld dropping without rdy.
- Out-of-range direction_id cannot occur, since NUM_DIR = 2^width. The SVA asserts this.
- Backpressure on one direction does not stall the other directions.

Test Plan:
- Reset and single response:
  - Stimulus: after rst, src1 sends a response with direction 2, txnid=0x26, with v_dir_rdy all 1.
  - Required: v_src_rdy[1]=1 in cycle N; v_dir_vld[2]=1 with txnid 0x26 in cycle N+1; no other v_dir_vld asserted; idle=1 by N+2.
- Round robin:
  - Stimulus: src0..src3 each hold 3 responses with direction 0; v_dir_rdy[0]=1.
  - Required: accept order src0,1,2,3,0,1,2,3,0,1,2,3; one accept per cycle; all 12 responses emitted in that order.
- Full and backpressure:
  - Stimulus: v_dir_rdy[1]=0; src0 streams to direction 1.
  - Required: exactly 4 accepts, then v_src_rdy[0]=0.
  - Stimulus: raise rdy for one cycle.
  - Required: one pop; no push in that same cycle; push resumes the following cycle.
- Parallel directions:
  - Stimulus: src0..src3 target directions 0..3 in the same cycle.
  - Required: all four v_src_rdy=1 together; all four v_dir_vld=1 next cycle; direction 3 blocked does not stall directions 0 to 2.
- Reset mid-stream:
  - Stimulus: direction 0 holds 3 entries; assert rst for 1 cycle.
  - Required: v_dir_vld=0 next cycle; every rr_ptr=0; the first post-reset grant goes to the lowest-indexed requester.
- Random soak:
  - Stimulus: 10k cycles of random vld/rdy across all sources and directions.
  - Required: the scoreboard shows no loss, no duplication, per-direction order preserved, and starvation bound of NUM_SRC-1 met.

Source files
------------

// File: rtl/wr_resp_sched.sv
// -----------------------------------------------------------------------------
// wr_resp_sched_pkg / wr_resp_sched
//
// Purpose:
//   Collects write responses from NUM_SRC completion sources (cache banks or
//   write ports). Each response goes into a FIFO for its destination direction.
//   The FIFO then returns it on that direction's valid/ready channel. Each
//   direction has its own round-robin arbiter, so the sources share the
//   direction fairly. The direction is chosen by txnid.direction_id.
//
// Ports:
//   clk        in   clock, every flop updates on its rising edge
//   rst        in   synchronous active-high reset
//   v_src_vld  in   [NUM_SRC]  per-source response valid
//   v_src_rdy  out  [NUM_SRC]  per-source accept, combinational from inputs
//                              and registered state (never from v_dir_rdy)
//   v_src_pld  in   wr_resp_pld_t[NUM_SRC]  response payload
//   v_dir_vld  out  [NUM_DIR]  per-direction response valid (FIFO not empty)
//   v_dir_rdy  in   [NUM_DIR]  per-direction downstream ready
//   v_dir_pld  out  wr_resp_pld_t[NUM_DIR]  FIFO head, carried unmodified
//   idle       out  all FIFOs empty and no source valid
// -----------------------------------------------------------------------------

package wr_resp_sched_pkg;

  typedef logic [1:0] dir_id_t;

  // txnid layout: {src_tag[1:0], direction_id[1:0], seq[3:0]}
  typedef struct packed {
    logic [1:0] src_tag;
    dir_id_t    direction_id;
    logic [3:0] seq;
  } txnid_t;

  typedef struct packed {
    txnid_t     txnid;
    logic [1:0] resp;
  } wr_resp_pld_t;

endpackage

module wr_resp_sched
  import wr_resp_sched_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int NUM_DIR    = 4,  // must equal 2**$bits(dir_id_t)
  parameter int FIFO_DEPTH = 4   // power of 2, at least 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] v_src_vld,
  output logic [NUM_SRC-1:0] v_src_rdy,
  input  wr_resp_pld_t       v_src_pld [NUM_SRC],
  output logic [NUM_DIR-1:0] v_dir_vld,
  input  logic [NUM_DIR-1:0] v_dir_rdy,
  output wr_resp_pld_t       v_dir_pld [NUM_DIR],
  output logic               idle
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIR_W = $bits(dir_id_t);

  // active_q is low during reset and for the first cycle after it. While it
  // is low, no source can be accepted.
  logic active_q, active_d;
  logic can_accept;

  logic [NUM_SRC-1:0] dir_grant [NUM_DIR];
  logic [NUM_DIR-1:0] dir_empty;

  always_comb begin
    active_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  // rst gates accepts combinationally. This stops a handshake that is in
  // flight when reset arrives from completing.
  assign can_accept = active_q && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIR; gi++) begin : g_dir
      logic [NUM_SRC-1:0] req;
      logic               grant_vld;
      logic [SRC_W-1:0]   grant_idx;
      logic               push;
      logic               pop;
      logic               dir_vld;
      wr_resp_pld_t       push_pld;

      logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
      logic [CNT_W-1:0]   cnt_q, cnt_d;
      logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
      logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
      wr_resp_pld_t       mem_q [FIFO_DEPTH];

      // Sources that want this direction.
      always_comb begin
        req = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
          req[s] = v_src_vld[s] &&
                   (v_src_pld[s].txnid.direction_id == DIR_W'(gi));
        end
      end

      // Round-robin search. It starts at rr_ptr_q and wraps modulo NUM_SRC.
      // The first requester found wins.
      always_comb begin : arb
        int               idx;
        logic [SRC_W-1:0] sel;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
          idx = int'(rr_ptr_q) + k;
          if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
          end
          sel = SRC_W'(idx);
          if (!grant_vld && req[sel]) begin
            grant_vld = 1'b1;
            grant_idx = sel;
          end
        end
      end

      // The full check looks only at the registered count. A pop in the same
      // cycle therefore cannot free room for a push until the next cycle.
      assign push     = grant_vld && can_accept &&
                        (cnt_q < CNT_W'(FIFO_DEPTH));
      assign dir_vld  = (cnt_q != '0) && !rst;
      assign pop      = dir_vld && v_dir_rdy[gi];
      assign push_pld = v_src_pld[grant_idx];

      assign dir_grant[gi] = push ? (NUM_SRC'(1) << grant_idx) : '0;
      assign dir_empty[gi] = (cnt_q == '0);
      assign v_dir_vld[gi] = dir_vld;
      assign v_dir_pld[gi] = mem_q[rd_ptr_q];

      always_comb begin
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          rr_ptr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0
                                                         : grant_idx + 1'b1;
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rr_ptr_q <= '0;
          cnt_q    <= '0;
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
        end else begin
          rr_ptr_q <= rr_ptr_d;
          cnt_q    <= cnt_d;
          rd_ptr_q <= rd_ptr_d;
          wr_ptr_q <= wr_ptr_d;
        end
      end

      // Storage needs no reset. Entries are visible only while cnt_q is
      // non-zero.
      always_ff @(posedge clk) begin
        if (push) begin
          mem_q[wr_ptr_q] <= push_pld;
        end
      end
    end
  endgenerate

  // Each source requests one direction, so at most one direction grant can be
  // set for any source.
  always_comb begin
    v_src_rdy = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      v_src_rdy = v_src_rdy | dir_grant[d];
    end
  end

  assign idle = ((&dir_empty) || rst) && !(|v_src_vld);

  // Source protocol checks.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src_chk
      a_vld_hold: assert property (@(posedge clk) disable iff (rst)
        (v_src_vld[gi] && !v_src_rdy[gi]) |=> v_src_vld[gi]);
      a_dir_range: assert property (@(posedge clk) disable iff (rst)
        v_src_vld[gi] |-> (int'(v_src_pld[gi].txnid.direction_id) < NUM_DIR));
    end
  endgenerate

endmodule

// File: tb/tb_wr_resp_sched.sv
module tb_wr_resp_sched;
  import wr_resp_sched_pkg::*;

  localparam int NS    = 4;
  localparam int ND    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] v_src_vld = '0;
  logic [NS-1:0] v_src_rdy;
  wr_resp_pld_t  v_src_pld [NS];
  logic [ND-1:0] v_dir_vld;
  logic [ND-1:0] v_dir_rdy = '1;
  wr_resp_pld_t  v_dir_pld [ND];
  logic          idle;

  int errors = 0;
  int checks = 0;

  // Soak state
  wr_resp_pld_t exp_q [ND][$];
  int seqc [NS][ND];
  int waitc [NS];
  int max_wait, spurious, multi_acc, n_push, n_pop;

  always #5 clk = ~clk;

  wr_resp_sched #(.NUM_SRC(NS), .NUM_DIR(ND), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .v_src_vld (v_src_vld),
    .v_src_rdy (v_src_rdy),
    .v_src_pld (v_src_pld),
    .v_dir_vld (v_dir_vld),
    .v_dir_rdy (v_dir_rdy),
    .v_dir_pld (v_dir_pld),
    .idle      (idle)
  );

  function automatic wr_resp_pld_t mk(input int s, input int d, input int q, input int r);
    wr_resp_pld_t p;
    p.txnid.src_tag      = 2'(s);
    p.txnid.direction_id = 2'(d);
    p.txnid.seq          = 4'(q);
    p.resp               = 2'(r);
    return p;
  endfunction

  // Inputs change 1 time unit after the rising edge. Outputs are sampled 2
  // units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    v_src_vld = '0;
    v_dir_rdy = '1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < NS; s++) v_src_pld[s] = mk(0, 0, 0, 0);
    rst = 1'b1; v_src_vld = '0; v_dir_rdy = '1;
    tick(); settle();
    checks++;
    if (v_dir_vld !== '0 || v_src_rdy !== '0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b rdy=%b idle=%b expected 0000 0000 1", v_dir_vld, v_src_rdy, idle);
    end
    tick();
    rst = 1'b0;
    v_src_vld = 4'b0010;
    v_src_pld[1] = mk(0, 2, 6, 0);
    settle();
    checks++;
    if (v_src_rdy !== 4'b0000) begin
      errors++; $display("FAIL rdy_first_cycle: got %b expected 0000", v_src_rdy);
    end
    tick(); settle();
    checks++;
    if (v_src_rdy !== 4'b0010) begin
      errors++; $display("FAIL single_accept: got %b expected 0010", v_src_rdy);
    end
    checks++;
    if (v_dir_vld !== 4'b0000) begin
      errors++; $display("FAIL no_bypass: got %b expected 0000", v_dir_vld);
    end
    tick();
    v_src_vld = '0;
    settle();
    checks++;
    if (v_dir_vld !== 4'b0100) begin
      errors++; $display("FAIL single_dir_vld: got %b expected 0100", v_dir_vld);
    end
    checks++;
    if (v_dir_pld[2].txnid !== 8'h26) begin
      errors++; $display("FAIL single_txnid: got %h expected 26", v_dir_pld[2].txnid);
    end
    tick(); settle();
    checks++;
    if (v_dir_vld !== 4'b0000 || idle !== 1'b1) begin
      errors++; $display("FAIL single_idle: got vld=%b idle=%b expected 0000 1", v_dir_vld, idle);
    end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    int sent [NS];
    int acc_i, out_i, first_c, last_c;
    logic [NS-1:0] acc, e;
    wr_resp_pld_t ep;
    do_reset();
    acc_i = 0; out_i = 0; first_c = -1; last_c = -1;
    for (int s = 0; s < NS; s++) begin
      sent[s] = 0;
      v_src_pld[s] = mk(s, 0, 0, 0);
    end
    v_src_vld = '1;
    for (int cyc = 0; cyc < 40 && (acc_i < 12 || out_i < 12); cyc++) begin
      settle();
      acc = v_src_rdy & v_src_vld;
      if (v_dir_vld[0]) begin
        ep = mk(out_i % 4, 0, out_i / 4, 0);
        checks++;
        if (v_dir_pld[0] !== ep) begin
          errors++; $display("FAIL rr_output[%0d]: got %h expected %h", out_i, v_dir_pld[0], ep);
        end
        out_i++;
      end
      if (acc != '0) begin
        e = 4'b0001 << (acc_i % 4);
        checks++;
        if (acc !== e) begin
          errors++; $display("FAIL rr_accept[%0d]: got %b expected %b", acc_i, acc, e);
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        acc_i++;
      end
      tick();
      for (int s = 0; s < NS; s++) begin
        if (acc[s]) begin
          sent[s]++;
          if (sent[s] == 3) v_src_vld[s] = 1'b0;
          else v_src_pld[s] = mk(s, 0, sent[s], 0);
        end
      end
    end
    checks++;
    if (acc_i != 12 || out_i != 12) begin
      errors++; $display("FAIL rr_count: got accepts=%0d outputs=%0d expected 12 12", acc_i, out_i);
    end
    checks++;
    if (last_c - first_c != 11) begin
      errors++; $display("FAIL rr_back_to_back: got span=%0d expected 11", last_c - first_c);
    end
    $display("test_round_robin done: accepts=%0d outputs=%0d", acc_i, out_i);
  endtask

  task automatic test_full();
    int n, seq;
    logic a;
    do_reset();
    v_dir_rdy = 4'b1101;
    seq = 0;
    v_src_pld[0] = mk(0, 1, 0, 0);
    v_src_vld = 4'b0001;
    n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      settle();
      a = v_src_rdy[0];
      if (a) n++;
      tick();
      if (a) begin
        seq++;
        v_src_pld[0] = mk(0, 1, seq, 0);
      end
    end
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL full_accepts: got %0d expected %0d", n, DEPTH);
    end
    v_dir_rdy[1] = 1'b1;
    settle();
    checks++;
    if (v_src_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL full_no_push_on_pop: got rdy=%b expected 0", v_src_rdy[0]);
    end
    checks++;
    if (v_dir_vld[1] !== 1'b1 || v_dir_pld[1].txnid.seq !== 4'd0) begin
      errors++; $display("FAIL full_head: got vld=%b seq=%0d expected 1 0", v_dir_vld[1], v_dir_pld[1].txnid.seq);
    end
    tick();
    v_dir_rdy[1] = 1'b0;
    settle();
    checks++;
    if (v_src_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL full_push_resume: got rdy=%b expected 1", v_src_rdy[0]);
    end
    checks++;
    if (v_dir_pld[1].txnid.seq !== 4'd1) begin
      errors++; $display("FAIL full_head_advance: got seq=%0d expected 1", v_dir_pld[1].txnid.seq);
    end
    tick();
    v_src_pld[0] = mk(0, 1, 5, 0);
    settle();
    checks++;
    if (v_src_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL full_refull: got rdy=%b expected 0", v_src_rdy[0]);
    end
    $display("test_full done: accepts=%0d", n);
  endtask

  task automatic test_parallel();
    int nacc [NS];
    int seq [NS];
    logic [NS-1:0] a;
    do_reset();
    v_dir_rdy = 4'b0111;
    for (int s = 0; s < NS; s++) begin
      nacc[s] = 0; seq[s] = 0;
      v_src_pld[s] = mk(s, s, 0, 0);
    end
    v_src_vld = '1;
    tick();
    for (int cyc = 0; cyc < 6; cyc++) begin
      settle();
      a = v_src_rdy & v_src_vld;
      if (cyc == 0) begin
        checks++;
        if (a !== 4'b1111) begin
          errors++; $display("FAIL par_all_rdy: got %b expected 1111", a);
        end
      end
      if (cyc == 1) begin
        checks++;
        if (v_dir_vld !== 4'b1111) begin
          errors++; $display("FAIL par_all_vld: got %b expected 1111", v_dir_vld);
        end
      end
      tick();
      for (int s = 0; s < NS; s++) begin
        if (a[s]) begin
          nacc[s]++; seq[s]++;
          v_src_pld[s] = mk(s, s, seq[s], 0);
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      checks++;
      if (nacc[s] != ((s == 3) ? DEPTH : 6)) begin
        errors++; $display("FAIL par_accepts[%0d]: got %0d expected %0d", s, nacc[s], (s == 3) ? DEPTH : 6);
      end
    end
    settle();
    checks++;
    if (v_src_rdy !== 4'b0111) begin
      errors++; $display("FAIL par_dir3_blocked: got %b expected 0111", v_src_rdy);
    end
    $display("test_parallel done");
  endtask

  task automatic test_reset_mid();
    logic [NS-1:0] a;
    do_reset();
    v_dir_rdy = 4'b1110;
    for (int s = 0; s < 3; s++) v_src_pld[s] = mk(s, 0, 0, 0);
    v_src_vld = 4'b0111;
    for (int cyc = 0; cyc < 8 && v_src_vld != '0; cyc++) begin
      settle();
      a = v_src_rdy & v_src_vld;
      tick();
      v_src_vld = v_src_vld & ~a;
    end
    settle();
    checks++;
    if (v_dir_vld[0] !== 1'b1 || v_src_vld !== '0) begin
      errors++; $display("FAIL mid_prefill: got vld=%b pending=%b expected 1 0000", v_dir_vld[0], v_src_vld);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (v_dir_vld !== 4'b0000) begin
      errors++; $display("FAIL mid_vld_in_reset: got %b expected 0000", v_dir_vld);
    end
    tick();
    rst = 1'b0;
    v_dir_rdy = '1;
    v_src_pld[1] = mk(1, 0, 7, 0);
    v_src_pld[3] = mk(3, 0, 7, 0);
    v_src_vld = 4'b1010;
    settle();
    checks++;
    if (v_dir_vld !== 4'b0000 || v_src_rdy !== 4'b0000) begin
      errors++; $display("FAIL mid_after_reset: got vld=%b rdy=%b expected 0000 0000", v_dir_vld, v_src_rdy);
    end
    tick(); settle();
    checks++;
    if (v_src_rdy !== 4'b0010) begin
      errors++; $display("FAIL mid_first_grant: got %b expected 0010", v_src_rdy);
    end
    tick();
    v_src_vld[1] = 1'b0;
    settle();
    checks++;
    if (v_dir_vld[0] !== 1'b1 || v_dir_pld[0] !== mk(1, 0, 7, 0)) begin
      errors++; $display("FAIL mid_fresh_head: got vld=%b pld=%h expected 1 %h", v_dir_vld[0], v_dir_pld[0], mk(1, 0, 7, 0));
    end
    checks++;
    if (v_src_rdy !== 4'b1000) begin
      errors++; $display("FAIL mid_second_grant: got %b expected 1000", v_src_rdy);
    end
    tick();
    v_src_vld = '0;
    $display("test_reset_mid done");
  endtask

  task automatic soak_cycle(input bit allow_new);
    logic [NS-1:0] acc;
    logic [ND-1:0] pop;
    int dacc [ND];
    int d;
    wr_resp_pld_t e;
    if (allow_new) begin
      for (int s = 0; s < NS; s++) begin
        if (!v_src_vld[s] && $urandom_range(0, 1) == 1) begin
          d = $urandom_range(0, ND - 1);
          v_src_pld[s] = mk(s, d, seqc[s][d], $urandom_range(0, 3));
          seqc[s][d] = (seqc[s][d] + 1) % 16;
          v_src_vld[s] = 1'b1;
          waitc[s] = 0;
        end
      end
      v_dir_rdy = 4'($urandom);
    end else begin
      v_dir_rdy = '1;
    end
    settle();
    acc = v_src_rdy & v_src_vld;
    pop = v_dir_vld & v_dir_rdy;
    if ((v_src_rdy & ~v_src_vld) != '0) spurious++;
    for (int k = 0; k < ND; k++) begin
      dacc[k] = 0;
      if (pop[k]) begin
        n_pop++;
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++; $display("FAIL soak_dup[%0d]: got %h expected nothing", k, v_dir_pld[k]);
        end else begin
          e = exp_q[k].pop_front();
          if (v_dir_pld[k] !== e) begin
            errors++; $display("FAIL soak_order[%0d]: got %h expected %h", k, v_dir_pld[k], e);
          end
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (acc[s]) begin
        d = int'(v_src_pld[s].txnid.direction_id);
        exp_q[d].push_back(v_src_pld[s]);
        dacc[d]++;
        n_push++;
      end
    end
    for (int k = 0; k < ND; k++) if (dacc[k] > 1) multi_acc++;
    for (int s = 0; s < NS; s++) begin
      if (v_src_vld[s] && !acc[s]) begin
        waitc[s] += dacc[int'(v_src_pld[s].txnid.direction_id)];
        if (waitc[s] > max_wait) max_wait = waitc[s];
      end
    end
    tick();
    v_src_vld = v_src_vld & ~acc;
  endtask

  task automatic test_soak();
    int qsum;
    do_reset();
    for (int s = 0; s < NS; s++) begin
      waitc[s] = 0;
      for (int d = 0; d < ND; d++) seqc[s][d] = 0;
    end
    for (int d = 0; d < ND; d++) exp_q[d].delete();
    max_wait = 0; spurious = 0; multi_acc = 0; n_push = 0; n_pop = 0;
    for (int cyc = 0; cyc < 10000; cyc++) soak_cycle(1'b1);
    qsum = 1;
    for (int cyc = 0; cyc < 300 && (qsum != 0 || v_src_vld != '0); cyc++) begin
      soak_cycle(1'b0);
      qsum = 0;
      for (int d = 0; d < ND; d++) qsum += exp_q[d].size();
    end
    settle();
    checks++;
    if (qsum != 0 || v_src_vld != '0) begin
      errors++; $display("FAIL soak_drain: got queued=%0d pending=%b expected 0 0000", qsum, v_src_vld);
    end
    checks++;
    if (n_push != n_pop) begin
      errors++; $display("FAIL soak_count: got pops=%0d expected %0d", n_pop, n_push);
    end
    checks++;
    if (idle !== 1'b1 || v_dir_vld !== '0) begin
      errors++; $display("FAIL soak_idle: got idle=%b vld=%b expected 1 0000", idle, v_dir_vld);
    end
    checks++;
    if (max_wait > NS - 1) begin
      errors++; $display("FAIL soak_starvation: got wait=%0d expected <=%0d", max_wait, NS - 1);
    end
    checks++;
    if (spurious != 0 || multi_acc != 0) begin
      errors++; $display("FAIL soak_grant_rules: got spurious=%0d multi=%0d expected 0 0", spurious, multi_acc);
    end
    $display("test_soak done: pushes=%0d pops=%0d max_wait=%0d", n_push, n_pop, max_wait);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full();
    test_parallel();
    test_reset_mid();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
